// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, reads the async ROM and
// holds the IF/ID register handed to decode over valid/ready.
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_DEPTH = 21,
  parameter int          ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              resetn,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_inst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [31:0]       if_inst,
  output logic [31:0]       if_pc,
  output logic              addr_err,
  output logic [31:0]       fetch_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(ROM_DEPTH);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic        xfer;
  logic        load;
  logic        pc_bad;
  logic        rd_bad;

  assign rom_addr = pc_q[ADDR_W+1:2];
  assign xfer     = valid_q & id_ready;
  assign load     = ~valid_q | id_ready;
  assign pc_bad   = (|pc_q[31:ADDR_W+2]) |
                    ({1'b0, rom_addr} >= DEPTH);
  assign rd_bad   = |redirect_pc[1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_valid) begin
          if (rd_bad) state_d = HALT;
        end else if (load && pc_bad) begin
          state_d = HALT;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // Redirect outranks load/stall; a transfer is counted regardless.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q + 32'(xfer);
    unique case (state_q)
      RUN: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          if (rd_bad) err_d = 1'b1;
          else        pc_d  = redirect_pc;
        end else if (load) begin
          if (pc_bad) begin
            err_d   = 1'b1;
            valid_d = 1'b0;
          end else begin
            inst_d  = rom_inst;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
          end
        end
      end
      HALT:    valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign if_valid  = valid_q;
  assign if_inst   = inst_q;
  assign if_pc     = ipc_q;
  assign addr_err  = err_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed walk through the program ROM,
// then random handshake/redirect/reset traffic against a model.
module tb_inst_fetch;

  localparam int DEPTH = 21;

  logic        clk;
  logic        resetn;
  logic [4:0]  rom_addr;
  logic [31:0] rom_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        addr_err;
  logic [31:0] fetch_cnt;

  logic [31:0] rom [32];

  int n_chk;
  int n_err;

  int          m_state;
  logic [31:0] m_pc;
  logic        m_v;
  logic [31:0] m_inst;
  logic [31:0] m_ipc;
  logic        m_err;
  logic [31:0] m_cnt;

  inst_fetch #(
    .RESET_PC (32'h0),
    .ROM_DEPTH(DEPTH),
    .ADDR_W   (5)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .rom_addr      (rom_addr),
    .rom_inst      (rom_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_ready      (id_ready),
    .if_valid      (if_valid),
    .if_inst       (if_inst),
    .if_pc         (if_pc),
    .addr_err      (addr_err),
    .fetch_cnt     (fetch_cnt)
  );

  assign rom_inst = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_state = 0;
    m_pc    = 32'h0;
    m_v     = 1'b0;
    m_inst  = 32'h0;
    m_ipc   = 32'h0;
    m_err   = 1'b0;
    m_cnt   = 32'h0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, {31'b0, if_valid}, {31'b0, m_v});
    check({tag, ".err"}, {31'b0, addr_err}, {31'b0, m_err});
    check({tag, ".cnt"}, fetch_cnt, m_cnt);
    check({tag, ".addr"}, {27'b0, rom_addr}, {27'b0, m_pc[6:2]});
    if (m_v) begin
      check({tag, ".inst"}, if_inst, m_inst);
      check({tag, ".pc"}, if_pc, m_ipc);
    end
  endtask

  // One clock: reference rules applied to the current model state.
  task automatic step(input logic rv, input logic [31:0] rpc,
                      input logic rdy, input string tag);
    logic [31:0] word;
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    if (m_v && rdy) m_cnt = m_cnt + 1;
    case (m_state)
      0: m_state = 1;
      1: begin
        if (rv) begin
          m_v = 1'b0;
          if (rpc % 4 != 0) begin
            m_err   = 1'b1;
            m_state = 2;
          end else begin
            m_pc = rpc;
          end
        end else if (!m_v || rdy) begin
          if (m_pc >= DEPTH * 4) begin
            m_err   = 1'b1;
            m_v     = 1'b0;
            m_state = 2;
          end else begin
            word   = rom[m_pc / 4];
            m_inst = word;
            m_ipc  = m_pc;
            m_v    = 1'b1;
            m_pc   = m_pc + 4;
          end
        end
      end
      default: m_v = 1'b0;
    endcase
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    m_reset();
    #1;
    check("rst.valid", {31'b0, if_valid}, 32'd0);
    check("rst.cnt", fetch_cnt, 32'd0);
    check("rst.err", {31'b0, addr_err}, 32'd0);
    check("rst.addr", {27'b0, rom_addr}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic run_to(input logic [31:0] target, input string tag);
    int k;
    k = 0;
    while (!(m_v && m_ipc == target) && k < 60) begin
      step(1'b0, 32'h0, 1'b1, tag);
      k++;
    end
    if (k >= 60) begin
      n_chk++;
      n_err++;
      $display("FAIL %s timeout waiting for if_pc=%h", tag, target);
    end
  endtask

  initial begin
    logic [31:0] rpc;
    logic        rv;
    n_chk = 0;
    n_err = 0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b1;
    resetn         = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = $urandom;
    rom[0]  = 32'h24010001;
    rom[1]  = 32'h00011100;
    rom[2]  = 32'h00411821;
    rom[3]  = 32'h00022082;
    rom[4]  = 32'h00642823;
    rom[12] = 32'h24010004;
    rom[13] = 32'h8C2A0013;
    rom[20] = 32'h08000000;

    do_reset();
    step(1'b0, 32'h0, 1'b1, "boot");
    check("boot.novalid", {31'b0, if_valid}, 32'd0);
    step(1'b0, 32'h0, 1'b1, "f0");
    check("f0.inst", if_inst, 32'h24010001);
    step(1'b0, 32'h0, 1'b1, "f1");
    check("f1.inst", if_inst, 32'h00011100);
    step(1'b0, 32'h0, 1'b1, "f2");
    check("f2.inst", if_inst, 32'h00411821);
    check("f2.cnt", fetch_cnt, 32'd2);
    step(1'b0, 32'h0, 1'b1, "f3");
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, "stall");
    check("stall.inst", if_inst, 32'h00022082);
    check("stall.cnt", fetch_cnt, 32'd3);
    step(1'b0, 32'h0, 1'b1, "rel");
    check("rel.pc", if_pc, 32'h10);
    check("rel.inst", if_inst, 32'h00642823);

    run_to(32'h2C, "to2c");
    step(1'b1, 32'h34, 1'b1, "redir");
    check("redir.bubble", {31'b0, if_valid}, 32'd0);
    step(1'b0, 32'h0, 1'b1, "tgt");
    check("tgt.pc", if_pc, 32'h34);
    check("tgt.inst", if_inst, 32'h8C2A0013);

    run_to(32'h50, "to50");
    step(1'b1, 32'h0, 1'b1, "loop");
    step(1'b0, 32'h0, 1'b1, "loop1");
    check("loop.inst", if_inst, 32'h24010001);
    check("loop.err", {31'b0, addr_err}, 32'd0);

    run_to(32'h50, "to50b");
    step(1'b0, 32'h0, 1'b1, "oor");
    check("oor.err", {31'b0, addr_err}, 32'd1);
    check("oor.valid", {31'b0, if_valid}, 32'd0);
    step(1'b1, 32'h0, 1'b1, "halt.redir");
    step(1'b0, 32'h0, 1'b1, "halt.hold");
    check("halt.addr", {27'b0, rom_addr}, 32'd21);

    do_reset();
    step(1'b0, 32'h0, 1'b1, "rb");
    step(1'b0, 32'h0, 1'b1, "rf0");
    check("rf0.pc", if_pc, 32'h0);
    step(1'b1, 32'h36, 1'b1, "mis");
    check("mis.err", {31'b0, addr_err}, 32'd1);

    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, "pre");
    step(1'b0, 32'h0, 1'b0, "st");
    resetn = 1'b0;
    m_reset();
    #2;
    check("async.valid", {31'b0, if_valid}, 32'd0);
    check("async.cnt", fetch_cnt, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0 ||
          (m_state == 2 && $urandom_range(0, 9) == 0)) begin
        do_reset();
      end else begin
        rv = ($urandom_range(0, 5) == 0);
        case ($urandom_range(0, 9))
          0: rpc = $urandom_range(0, 22) * 4 + $urandom_range(1, 3);
          1: rpc = $urandom_range(21, 31) * 4;
          2: rpc = 32'hFFFF_FFFC;
          default: rpc = $urandom_range(0, 20) * 4;
        endcase
        step(rv, rpc, 1'($urandom_range(0, 3) != 0), "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
